// File: rtl/gbp_ghist.sv
// Speculative global-history register for the gbp predictor, with one
// checkpoint per in-flight predicted branch so a mispredict can rebuild the history.
module gbp_ghist #(
    parameter int HIST_BITS  = 8,
    parameter int INDEX_BITS = 8,
    parameter int PC_OFFSET  = 1,
    parameter int VLEN       = 39,
    parameter int CKPT_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_bp_i,
    input  logic                          debug_mode_i,
    input  logic [VLEN-1:0]               vpc_i,
    input  logic                          predict_valid_i,
    input  logic                          predict_taken_i,
    output logic                          predict_ready_o,
    input  logic                          resolve_valid_i,
    input  logic                          resolve_taken_i,
    input  logic                          resolve_mispredict_i,
    output logic [INDEX_BITS-1:0]         index_o,
    output logic [HIST_BITS-1:0]          ghist_o,
    output logic [$clog2(CKPT_DEPTH):0]   occupancy_o,
    output logic                          resolve_err_o
);

    localparam int PW = $clog2(CKPT_DEPTH);
    localparam int CW = PW + 1;

    logic [HIST_BITS-1:0] ghist_q, ghist_d;
    logic [PW-1:0]        wrPtr_q, wrPtr_d;
    logic [PW-1:0]        rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_q, err_d;
    logic [HIST_BITS-1:0] ckpt_q [CKPT_DEPTH];

    logic                 push;
    logic                 pop;
    logic [HIST_BITS-1:0] oldest;
    logic                 unused;

    assign predict_ready_o = (count_q != CW'(CKPT_DEPTH));
    assign push            = predict_valid_i & predict_ready_o & ~debug_mode_i;
    assign pop             = resolve_valid_i & (count_q != '0);
    assign oldest          = ckpt_q[rdPtr_q];

    assign index_o       = vpc_i[PC_OFFSET+INDEX_BITS-1:PC_OFFSET] ^ INDEX_BITS'(ghist_q);
    assign ghist_o       = ghist_q;
    assign occupancy_o   = count_q;
    assign resolve_err_o = err_q;

    assign unused = ^{vpc_i[VLEN-1:PC_OFFSET+INDEX_BITS], vpc_i[PC_OFFSET-1:0],
                      oldest[HIST_BITS-1]};

    // Flush beats recovery, recovery beats the ordinary push/pop traffic.
    always_comb begin
        ghist_d = ghist_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        err_d   = err_q | (resolve_valid_i & (count_q == '0));
        if (flush_bp_i) begin
            ghist_d = '0;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else if (pop && resolve_mispredict_i) begin
            // Younger branches are squashed, so every checkpoint is discarded.
            ghist_d = {oldest[HIST_BITS-2:0], resolve_taken_i};
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                ghist_d = {ghist_q[HIST_BITS-2:0], predict_taken_i};
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ghist_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ghist_q <= ghist_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Checkpoint storage needs no reset; the pointers decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ckpt_q[wrPtr_q] <= ghist_q;
        end
    end

endmodule
